// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, ALU operation codes and decoded payload type
// Purpose: common definitions for decode_comb and decode_stage.
//   OPC_*      : RV32I/RV64I major opcodes handled by the decoder
//   alu_op_e   : ALU operation encoding driven on alu_op
//   decoded_t  : one decoded instruction; op_b is held at full 64-bit width
//                and narrowed to XLEN by the stage
//   f3_alu     : register/immediate arithmetic funct3 -> ALU operation
package decode_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_PASSB = 5'd10
  } alu_op_e;

  typedef struct packed {
    logic        illegal;
    logic        reg_write;
    logic        use_imm;
    logic        mem_read;
    logic        mem_write;
    alu_op_e     alu_op;
    logic [2:0]  mem_funct3;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [63:0] op_b;
  } decoded_t;

  // Base (non-SUB/SRA) operation for OP and OP-IMM funct3 values.
  function automatic alu_op_e f3_alu(input logic [2:0] funct3);
    case (funct3)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational instruction word to decoded_t translation
// Purpose: decodes OP, OP-IMM, LUI, LOAD and STORE and flags everything else
// as illegal. No state.
// Ports:
//   instruction : in  raw 32-bit instruction word
//   decoded     : out decoded payload (decode_pkg::decoded_t)
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instruction,
  output decoded_t    decoded
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm_i;
  logic [63:0] imm_s;
  logic [63:0] imm_u;
  logic [63:0] shamt;
  logic        slli_bad;
  logic        srxi_bad;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign imm_i  = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_s  = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_u  = {{32{instruction[31]}}, instruction[31:12], 12'b0};

  // RV64 uses a 6-bit shamt, so bit 25 moves from "must be zero" into the amount.
  // instr[30] is the only other bit allowed, and only for the right shifts (SRAI).
  generate
    if (XLEN == 64) begin : g_sh64
      assign shamt    = {58'b0, instruction[25:20]};
      assign slli_bad = (instruction[31:26] != 6'b0);
      assign srxi_bad = ({instruction[31], instruction[29:26]} != 5'b0);
    end else begin : g_sh32
      assign shamt    = {59'b0, instruction[24:20]};
      assign slli_bad = (instruction[31:25] != 7'b0);
      assign srxi_bad = ({instruction[31], instruction[29:25]} != 6'b0);
    end
  endgenerate

  always_comb begin
    decoded            = '0;
    decoded.alu_op     = ALU_ADD;
    decoded.mem_funct3 = funct3;
    decoded.rs1_addr   = instruction[19:15];
    decoded.rs2_addr   = instruction[24:20];
    decoded.rd_addr    = instruction[11:7];

    if (instruction[1:0] != 2'b11) begin
      decoded.illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          decoded.reg_write = 1'b1;
          if (funct7 == 7'b0000000) begin
            decoded.alu_op = f3_alu(funct3);
          end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            decoded.alu_op = ALU_SUB;
          end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
            decoded.alu_op = ALU_SRA;
          end else begin
            decoded.illegal = 1'b1;
          end
        end
        OPC_OPIMM: begin
          decoded.reg_write = 1'b1;
          decoded.use_imm   = 1'b1;
          if (funct3 == 3'b001) begin
            decoded.alu_op  = ALU_SLL;
            decoded.op_b    = shamt;
            decoded.illegal = slli_bad;
          end else if (funct3 == 3'b101) begin
            decoded.alu_op  = instruction[30] ? ALU_SRA : ALU_SRL;
            decoded.op_b    = shamt;
            decoded.illegal = srxi_bad;
          end else begin
            decoded.alu_op  = f3_alu(funct3);
            decoded.op_b    = imm_i;
          end
        end
        OPC_LUI: begin
          decoded.reg_write = 1'b1;
          decoded.use_imm   = 1'b1;
          decoded.alu_op    = ALU_PASSB;
          decoded.op_b      = imm_u;
        end
        OPC_LOAD: begin
          decoded.reg_write = 1'b1;
          decoded.use_imm   = 1'b1;
          decoded.mem_read  = 1'b1;
          decoded.op_b      = imm_i;
          // LWU (110) exists only on RV64; 111 is unassigned everywhere.
          decoded.illegal   = (funct3 == 3'b111) || (XLEN == 32 && funct3 == 3'b110);
        end
        OPC_STORE: begin
          decoded.use_imm   = 1'b1;
          decoded.mem_write = 1'b1;
          decoded.op_b      = imm_s;
          decoded.illegal   = funct3[2];
        end
        default: decoded.illegal = 1'b1;
      endcase
    end

    // Illegal entries still travel down the pipe so execute can trap, but
    // must not have any architectural side effect.
    if (decoded.illegal) begin
      decoded.reg_write = 1'b0;
      decoded.mem_read  = 1'b0;
      decoded.mem_write = 1'b0;
      decoded.alu_op    = ALU_ADD;
    end
    if (decoded.rd_addr == 5'd0) begin
      decoded.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with valid/ready handshake and flush
// Purpose: wraps decode_comb with a one-entry pipeline register between fetch
// and execute. Full throughput with no bubble: in_ready = !out_valid || out_ready.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : drop held entry and any same-cycle accept
//   in_valid/in_ready   : fetch-side handshake, instruction = raw word
//   out_valid/out_ready : execute-side handshake
//   reg_write, use_imm, op_b, alu_op, mem_read, mem_write, mem_funct3,
//   rs1_addr, rs2_addr, rd_addr, illegal : registered decoded payload
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                reg_write,
  output logic                use_imm,
  output logic [XLEN-1:0]     op_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic [2:0]          mem_funct3,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  output logic [4:0]          rd_addr,
  output logic                illegal
);

  decoded_t dec;
  decoded_t held;
  logic     valid_q;
  logic     accept;

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .instruction (instruction),
    .decoded     (dec)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Payload is only loaded on accept, so it holds across stalls and after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      held    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      held    <= dec;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  generate
    if (XLEN < 64) begin : g_narrow
      logic unused_op_b_hi;
      assign unused_op_b_hi = ^held.op_b[63:XLEN];
    end
  endgenerate

  assign out_valid  = valid_q;
  assign reg_write  = held.reg_write;
  assign use_imm    = held.use_imm;
  assign op_b       = held.op_b[XLEN-1:0];
  assign alu_op     = ALU_OP_W'(held.alu_op);
  assign mem_read   = held.mem_read;
  assign mem_write  = held.mem_write;
  assign mem_funct3 = held.mem_funct3;
  assign rs1_addr   = held.rs1_addr;
  assign rs2_addr   = held.rs2_addr;
  assign rd_addr    = held.rd_addr;
  assign illegal    = held.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (XLEN=32)
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        in_ready, out_valid, reg_write, use_imm, mem_read, mem_write, illegal;
  logic [31:0] op_b;
  logic [4:0]  alu_op, rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  mem_funct3;

  decode_stage #(.XLEN(32), .ALU_OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write(reg_write), .use_imm(use_imm), .op_b(op_b), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit        ill, rw, ui, mr, mw;
    bit [4:0]  alu;
    bit [2:0]  f3;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] opb;
  } exp_t;

  int   checks = 0;
  int   passes = 0;
  exp_t m_entry = '0;
  bit   m_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Instruction-set level view: what each RV32I instruction class must produce.
  function automatic exp_t model(input bit [31:0] i);
    exp_t e;
    int   alu_by_f3 [8];
    bit   ok;
    int   f3;
    bit [6:0] f7;
    alu_by_f3 = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = int'(i[14:12]);
    f7 = i[31:25];
    e = '0;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.f3 = i[14:12];
    ok = 1'b1;
    case (i[6:0])
      7'h33: begin
        e.rw = 1;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.alu = (f7 == 7'h20) ? ((f3 == 0) ? 5'd1 : 5'd7) : 5'(alu_by_f3[f3]);
      end
      7'h13: begin
        e.rw = 1; e.ui = 1;
        if (f3 == 1) begin
          e.opb = {27'b0, i[24:20]}; e.alu = 2; ok = (f7 == 0);
        end else if (f3 == 5) begin
          e.opb = {27'b0, i[24:20]}; e.alu = i[30] ? 5'd7 : 5'd6;
          ok = (f7 == 7'h00) || (f7 == 7'h20);
        end else begin
          e.opb = {{20{i[31]}}, i[31:20]}; e.alu = 5'(alu_by_f3[f3]);
        end
      end
      7'h37: begin e.rw = 1; e.ui = 1; e.alu = 10; e.opb = {i[31:12], 12'h000}; end
      7'h03: begin
        e.rw = 1; e.ui = 1; e.mr = 1; e.opb = {{20{i[31]}}, i[31:20]};
        ok = (f3 < 6);
      end
      7'h23: begin
        e.ui = 1; e.mw = 1; e.opb = {{20{i[31]}}, i[31:25], i[11:7]};
        ok = (f3 < 4);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin e.ill = 1; e.rw = 0; e.mr = 0; e.mw = 0; e.alu = 0; end
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  always @(negedge rst_n) begin
    m_valid = 1'b0;
    m_entry = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) m_valid = 1'b0;
      else if (in_valid && (!m_valid || out_ready)) begin
        m_entry = model(instruction);
        m_valid = 1'b1;
      end else if (out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("illegal", illegal, m_entry.ill);
    chk("reg_write", reg_write, m_entry.rw);
    chk("mem_read", mem_read, m_entry.mr);
    chk("mem_write", mem_write, m_entry.mw);
    chk("alu_op", alu_op, m_entry.alu);
    chk("mem_funct3", mem_funct3, m_entry.f3);
    chk("addrs", {rs1_addr, rs2_addr, rd_addr}, {m_entry.rs1, m_entry.rs2, m_entry.rd});
    if (!m_entry.ill) begin
      chk("use_imm", use_imm, m_entry.ui);
      chk("op_b", op_b, m_entry.opb);
    end
  end

  task automatic drive(input bit v, input bit [31:0] ins, input bit ordy, input bit fl);
    in_valid = v; instruction = ins; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream [4];
  logic [4:0]  stream_alu [4];
  logic [31:0] bad [4];
  exp_t        pin;

  initial begin
    stream     = '{32'h00500093, 32'h002081B3, 32'h12345237, 32'h00309293};
    stream_alu = '{5'd0, 5'd0, 5'd10, 5'd2};
    bad        = '{32'h40309293, 32'h402091B3, 32'h0000E283, 32'h00004023};

    pin = model(32'h4083D313);
    chk("pin_srai", {pin.alu, pin.opb, pin.rd}, {5'd7, 32'd8, 5'd6});
    pin = model(32'h00512623);
    chk("pin_sw", {pin.mw, pin.rw, pin.opb}, {1'b1, 1'b0, 32'd12});
    pin = model(32'h0000000B);
    chk("pin_ill", pin.ill, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {out_valid, reg_write, op_b, alu_op, illegal, rd_addr}, 0);
    rst_n = 1'b1;

    drive(1, 32'h4083D313, 1, 0);
    chk("srai", {out_valid, alu_op, op_b, use_imm, rs1_addr, rd_addr, reg_write, illegal},
        {1'b1, 5'd7, 32'd8, 1'b1, 5'd7, 5'd6, 1'b1, 1'b0});
    drive(1, 32'h40208033, 1, 0);
    chk("sub_x0", {alu_op, use_imm, op_b, reg_write}, {5'd1, 1'b0, 32'd0, 1'b0});
    drive(1, 32'hFFC12283, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h00512623, 0, 0);
      chk("lw_stall", {in_ready, out_valid, mem_read, op_b, mem_funct3},
          {1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 3'b010});
    end
    drive(1, 32'h00512623, 1, 0);
    chk("sw", {mem_write, op_b, reg_write, mem_read}, {1'b1, 32'd12, 1'b0, 1'b0});
    drive(1, 32'h0000000B, 1, 0);
    chk("illegal_0b", {illegal, reg_write, mem_read, mem_write}, {1'b1, 3'b000});

    for (int k = 0; k < 4; k++) begin
      drive(1, stream[k], 1, 0);
      chk("stream", {out_valid, in_ready, alu_op}, {1'b1, 1'b1, stream_alu[k]});
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, bad[k], 1, 0);
      chk("bad_enc", illegal, 1'b1);
    end
    drive(1, 32'hFFFFF237, 1, 0);
    chk("lui_neg", op_b, 32'hFFFFF000);

    drive(1, 32'h00500093, 1, 0);
    drive(1, 32'h002081B3, 1, 1);
    chk("flush", {out_valid, rd_addr}, {1'b0, 5'd1});
    drive(0, 32'h0, 1, 0);
    chk("after_flush", out_valid, 1'b0);

    drive(1, 32'h12345237, 0, 0);
    chk("pre_reset", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", {out_valid, reg_write, op_b, rd_addr}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 32'h00309293, 1, 0);
    chk("post_reset", {out_valid, alu_op, op_b}, {1'b1, 5'd2, 32'd3});
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction decode stage; successor to the combinational control unit.
- Parametrised in XLEN. Adds valid/ready handshakes on both sides, a one-entry pipeline register, flush, illegal-instruction detection, and LOAD/STORE/LUI decode.
- Sits between the fetch stage and the register-file/ALU execute stage.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sets op_b width and shamt width (5 or 6 bits).
- ALU_OP_W, 5, width of the alu_op field.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards the held entry and any same-cycle accept.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept.
- instruction  in  32  raw instruction word.
- out_valid  out  1  decoded entry held.
- out_ready  in  1  execute consumes the entry.
- reg_write  out  1  rd is written (rd != 0 and the class writes).
- use_imm  out  1  ALU B comes from op_b, not rs2.
- op_b  out  XLEN  sign-extended immediate; 0 for R-type.
- alu_op  out  ALU_OP_W  operation code from the package enum.
- mem_read  out  1  LOAD.
- mem_write  out  1  STORE.
- mem_funct3  out  3  load/store size and sign, copied from funct3.
- rs1_addr, rs2_addr, rd_addr  out  5 each  register addresses.
- illegal  out  1  unsupported or malformed encoding.

Behaviour:
- Reset (rst_n=0, asynchronous): all registered outputs are 0, out_valid=0.
- in_ready = !out_valid || out_ready (combinational; no bubble under full throughput).
- Accept: in_valid && in_ready && !flush. The entry is registered next edge, so latency is 1 cycle.
- Accept with out_valid && out_ready in the same cycle replaces the entry; out_valid stays 1.
- out_ready without a new accept: out_valid goes to 0; payload holds its last value.
- out_valid=1 && !out_ready: payload and out_valid are stable (required hold).
- flush=1: out_valid goes to 0 at the next edge and no accept happens that cycle; flush overrides everything except reset.
- Decode by opcode:
  - 0110011 OP: use_imm=0, op_b=0. funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise illegal.
  - 0010011 OP-IMM: I-immediate. funct3 001/101 are shifts: op_b = zero-extended shamt. instr[30] selects SRA vs SRL.
    - SLLI requires instr[30]=0.
    - Other bits of instr[31:26] (or [31:25] for XLEN=32) must be 0; otherwise illegal.
  - 0110111 LUI: op_b = {instr[31:12],12'b0} sign-extended to XLEN; alu_op=PASSB.
  - 0000011 LOAD: alu_op=ADD, I-immediate, mem_read=1. funct3 110 is illegal for XLEN=32; 111 is always illegal.
  - 0100011 STORE: alu_op=ADD, S-immediate {instr[31:25],instr[11:7]}, mem_write=1, reg_write=0. funct3 >= 100 is illegal for XLEN=32; > 011 is always illegal.
  - Any other opcode, or instr[1:0] != 11: illegal.
- Illegal entries: illegal=1, reg_write=mem_read=mem_write=0, alu_op=ADD. The entry still occupies a slot so execute can trap.
- reg_write is forced to 0 when rd=0.
- Unused address fields output raw instruction bits (no masking).

Decomposition:
- Package decode_pkg holds:
  - opcode localparams: OPC_OP, OPC_OPIMM, OPC_LUI, OPC_LOAD, OPC_STORE.
  - alu_op enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - struct decoded_t carrying all payload fields.
- Sub-module decode_comb: purely combinational, instruction -> decoded_t.
- decode_stage wraps decode_comb with the handshake register and flush.

Test Plan:
- Reset, then 0x4083D313 (SRAI x6,x7,8) with in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_op=SRA(7), op_b=8, use_imm=1, rs1=7, rd=6, reg_write=1, illegal=0.
- 0x40208033 (SUB x0,x1,x2) -> alu_op=SUB(1), use_imm=0, op_b=0, reg_write=0 because rd=0.
- 0xFFC12283 (LW x5,-4(x2)) with out_ready=0 for 3 cycles -> in_ready=0; payload stays mem_read=1, op_b=0xFFFFFFFC, mem_funct3=010; accepted once out_ready=1.
- 0x00512623 (SW x5,12(x2)) -> mem_write=1, op_b=12, reg_write=0. Then 0x0000000B -> illegal=1, all write enables 0.
- Back-to-back stream of 4 instructions with out_ready=1 -> 4 consecutive out_valid cycles, in_ready stays 1, outputs in order.
- flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, new instruction not accepted. Also: rst_n dropped mid-stream -> outputs 0 immediately, without waiting for a clock edge.
